// File: rtl/gci_hub_pkg.sv
// Shared definitions for the GCI hub node arbiter: FSM encoding, node count,
// credit width and a one-hot helper.
package gci_hub_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RELOAD = 2'd1,
      GRANT  = 2'd2
   } arbState_t;

   localparam int NODE_COUNT = 4;
   localparam int CREDIT_W   = 9;

   function automatic logic [NODE_COUNT-1:0] oneHot(input logic [1:0] idx);
      logic [NODE_COUNT-1:0] vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/gci_hub_rr_pick.sv
// Combinational round-robin search: first eligible node in the order
// last+1, last+2, last+3, last (mod 4).
module gci_hub_rr_pick
   import gci_hub_pkg::*;
(
   input  logic [NODE_COUNT-1:0] eligible,
   input  logic [1:0]            last,
   output logic                  found,
   output logic [1:0]            index
);

   // Walk the order backwards so the earliest candidate overwrites later ones.
   always_comb begin
      found = 1'b0;
      index = 2'd0;
      for (int k = NODE_COUNT; k >= 1; k--) begin
         if (eligible[last + 2'(k)]) begin
            found = 1'b1;
            index = last + 2'(k);
         end
      end
   end

endmodule

// File: rtl/gci_hub_node_arbiter.sv
// Credit-weighted round-robin arbiter for the four GCI nodes sharing the hub's
// downstream path, with a watchdog that revokes grants held too long.
module gci_hub_node_arbiter
   import gci_hub_pkg::*;
#(
   parameter logic [15:0] P_TIMEOUT = 16'd1024
)
(
   input  logic       iCLOCK,
   input  logic       iRESET_SYNC,
   input  logic       iNODE1_REQ,
   input  logic       iNODE2_REQ,
   input  logic       iNODE3_REQ,
   input  logic       iNODE4_REQ,
   input  logic [7:0] iNODE1_PRIORITY,
   input  logic [7:0] iNODE2_PRIORITY,
   input  logic [7:0] iNODE3_PRIORITY,
   input  logic [7:0] iNODE4_PRIORITY,
   input  logic       iRELEASE,
   output logic [3:0] oGRANT,
   output logic       oGRANT_VALID,
   output logic [1:0] oGRANT_ID,
   output logic       oTIMEOUT
);

   localparam bit          WATCHDOG_ON  = (P_TIMEOUT != 16'd0);
   localparam logic [15:0] TIMEOUT_LAST = P_TIMEOUT - 16'd1;

   arbState_t             state, nextState;
   logic [CREDIT_W-1:0]   credit [NODE_COUNT];
   logic [CREDIT_W-1:0]   nextCredit [NODE_COUNT];
   logic [1:0]            lastIdx, nextLast;
   logic [15:0]           holdCnt, nextHold;
   logic [NODE_COUNT-1:0] grantR, nextGrant;
   logic                  validR, nextValid;
   logic [1:0]            idR, nextId;
   logic                  timeoutR, nextTimeout;

   logic [NODE_COUNT-1:0] req;
   logic [7:0]            prio [NODE_COUNT];
   logic [NODE_COUNT-1:0] eligible;
   logic                  pickFound;
   logic [1:0]            pickIdx;
   logic                  timeoutHit;

   assign req     = {iNODE4_REQ, iNODE3_REQ, iNODE2_REQ, iNODE1_REQ};
   assign prio[0] = iNODE1_PRIORITY;
   assign prio[1] = iNODE2_PRIORITY;
   assign prio[2] = iNODE3_PRIORITY;
   assign prio[3] = iNODE4_PRIORITY;

   always_comb begin
      for (int k = 0; k < NODE_COUNT; k++) begin
         eligible[k] = req[k] && (credit[k] != '0);
      end
   end

   gci_hub_rr_pick uPick (
      .eligible (eligible),
      .last     (lastIdx),
      .found    (pickFound),
      .index    (pickIdx)
   );

   // holdCnt counts edges already spent in GRANT, so hitting P_TIMEOUT-1 here
   // means the grant has been visible for exactly P_TIMEOUT cycles.
   assign timeoutHit = WATCHDOG_ON && (holdCnt == TIMEOUT_LAST);

   always_comb begin
      nextState   = state;
      nextCredit  = credit;
      nextLast    = lastIdx;
      nextHold    = holdCnt;
      nextGrant   = grantR;
      nextId      = idR;
      nextTimeout = 1'b0;
      case (state)
         IDLE: begin
            if (pickFound) begin
               nextGrant           = oneHot(pickIdx);
               nextId              = pickIdx;
               nextCredit[pickIdx] = credit[pickIdx] - 9'd1;
               nextLast            = pickIdx;
               nextHold            = 16'd0;
               nextState           = GRANT;
            end else if (|req) begin
               nextState = RELOAD;
            end
         end
         RELOAD: begin
            // Weight of 0 still yields one grant per round.
            for (int k = 0; k < NODE_COUNT; k++) begin
               nextCredit[k] = {1'b0, prio[k]} + 9'd1;
            end
            nextState = IDLE;
         end
         GRANT: begin
            nextHold = (holdCnt == 16'hFFFF) ? holdCnt : holdCnt + 16'd1;
            if (iRELEASE) begin
               nextGrant = '0;
               nextId    = 2'd0;
               nextState = IDLE;
            end else if (timeoutHit) begin
               nextGrant   = '0;
               nextId      = 2'd0;
               nextTimeout = 1'b1;
               nextState   = IDLE;
            end
         end
         default: begin
            nextGrant = '0;
            nextId    = 2'd0;
            nextState = IDLE;
         end
      endcase
      nextValid = |nextGrant;
   end

   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         state    <= IDLE;
         lastIdx  <= 2'd3;
         holdCnt  <= 16'd0;
         grantR   <= '0;
         validR   <= 1'b0;
         idR      <= 2'd0;
         timeoutR <= 1'b0;
         for (int k = 0; k < NODE_COUNT; k++) begin
            credit[k] <= '0;
         end
      end else begin
         state    <= nextState;
         lastIdx  <= nextLast;
         holdCnt  <= nextHold;
         grantR   <= nextGrant;
         validR   <= nextValid;
         idR      <= nextId;
         timeoutR <= nextTimeout;
         for (int k = 0; k < NODE_COUNT; k++) begin
            credit[k] <= nextCredit[k];
         end
      end
   end

   assign oGRANT       = grantR;
   assign oGRANT_VALID = validR;
   assign oGRANT_ID    = idR;
   assign oTIMEOUT     = timeoutR;

endmodule

// File: tb/tb_gci_hub_node_arbiter.sv
// Directed bench for gci_hub_node_arbiter: per-cycle vector table plus
// hand-written watchdog/release and reset-mid-grant sequences.
module tb_gci_hub_node_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [7:0] p1;
   logic       rel;

   logic [3:0] g8, g4;
   logic       v8, v4;
   logic [1:0] id8, id4;
   logic       to8, to4;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   gci_hub_node_arbiter #(.P_TIMEOUT(16'd8)) dut8 (
      .iCLOCK(clk), .iRESET_SYNC(rst),
      .iNODE1_REQ(req[0]), .iNODE2_REQ(req[1]), .iNODE3_REQ(req[2]), .iNODE4_REQ(req[3]),
      .iNODE1_PRIORITY(p1), .iNODE2_PRIORITY(8'd0), .iNODE3_PRIORITY(8'd0), .iNODE4_PRIORITY(8'd0),
      .iRELEASE(rel),
      .oGRANT(g8), .oGRANT_VALID(v8), .oGRANT_ID(id8), .oTIMEOUT(to8)
   );

   gci_hub_node_arbiter #(.P_TIMEOUT(16'd4)) dut4 (
      .iCLOCK(clk), .iRESET_SYNC(rst),
      .iNODE1_REQ(req[0]), .iNODE2_REQ(req[1]), .iNODE3_REQ(req[2]), .iNODE4_REQ(req[3]),
      .iNODE1_PRIORITY(p1), .iNODE2_PRIORITY(8'd0), .iNODE3_PRIORITY(8'd0), .iNODE4_PRIORITY(8'd0),
      .iRELEASE(rel),
      .oGRANT(g4), .oGRANT_VALID(v4), .oGRANT_ID(id4), .oTIMEOUT(to4)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       rel;
      logic [7:0] p1;
      logic [3:0] expG;
      logic       expTo;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [1:0] idOf(input logic [3:0] g);
      case (g)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // {grant, valid, id, timeout}
   function automatic logic [7:0] expPack(input logic [3:0] g, input logic t);
      return {g, |g, idOf(g), t};
   endfunction

   task automatic addVec(input logic r, input logic [3:0] q, input logic l,
                         input logic [7:0] p, input logic [3:0] eg, input logic et);
      vec_t v;
      v.rst = r; v.req = q; v.rel = l; v.p1 = p; v.expG = eg; v.expTo = et;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %b expected %b", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; req = 4'b0; p1 = 8'd0; rel = 1'b0;

      // Reset, then node2 alone: RELOAD, IDLE, grant on the 3rd edge
      addVec(1, 4'b0000, 0, 8'd0, 4'b0000, 0);
      addVec(1, 4'b0000, 0, 8'd0, 4'b0000, 0);
      addVec(0, 4'b0010, 0, 8'd0, 4'b0000, 0);
      addVec(0, 4'b0010, 0, 8'd0, 4'b0000, 0);
      addVec(0, 4'b0010, 0, 8'd0, 4'b0010, 0);
      addVec(0, 4'b0000, 1, 8'd0, 4'b0000, 0);

      // All request, weights 0, release after 2 grant cycles
      addVec(1, 4'b0000, 0, 8'd0, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd0, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd0, 4'b0000, 0);
      for (int n = 0; n < 4; n++) begin
         addVec(0, 4'b1111, 0, 8'd0, 4'(1 << n), 0);
         addVec(0, 4'b1111, 0, 8'd0, 4'(1 << n), 0);
         addVec(0, 4'b1111, 1, 8'd0, 4'b0000, 0);
      end
      addVec(0, 4'b1111, 0, 8'd0, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd0, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd0, 4'b0001, 0);
      addVec(0, 4'b1111, 1, 8'd0, 4'b0000, 0);

      // Node1 weight 2: round n1 n2 n3 n4 n1 n1, then reload and n2 next
      addVec(1, 4'b0000, 0, 8'd2, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd2, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd2, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd2, 4'b0001, 0);
      addVec(0, 4'b1111, 1, 8'd2, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd2, 4'b0010, 0);
      addVec(0, 4'b1111, 1, 8'd2, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd2, 4'b0100, 0);
      addVec(0, 4'b1111, 1, 8'd2, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd2, 4'b1000, 0);
      addVec(0, 4'b1111, 1, 8'd2, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd2, 4'b0001, 0);
      addVec(0, 4'b1111, 1, 8'd2, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd2, 4'b0001, 0);
      addVec(0, 4'b1111, 1, 8'd2, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd2, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd2, 4'b0000, 0);
      addVec(0, 4'b1111, 0, 8'd2, 4'b0010, 0);
      addVec(0, 4'b1111, 1, 8'd2, 4'b0000, 0);

      // Watchdog at 8: node3 holds 8 cycles, revoke pulses, node1 served
      addVec(1, 4'b0000, 0, 8'd0, 4'b0000, 0);
      addVec(0, 4'b0100, 0, 8'd0, 4'b0000, 0);
      addVec(0, 4'b0100, 0, 8'd0, 4'b0000, 0);
      addVec(0, 4'b0100, 0, 8'd0, 4'b0100, 0);
      for (int c = 0; c < 7; c++) addVec(0, 4'b0101, 0, 8'd0, 4'b0100, 0);
      addVec(0, 4'b0101, 0, 8'd0, 4'b0000, 1);
      addVec(0, 4'b0101, 0, 8'd0, 4'b0001, 0);
      addVec(0, 4'b0000, 1, 8'd0, 4'b0000, 0);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; req = vecs[i].req; rel = vecs[i].rel; p1 = vecs[i].p1;
         step();
         check($sformatf("vec%0d", i), {g8, v8, id8, to8}, expPack(vecs[i].expG, vecs[i].expTo));
      end

      // Release and watchdog coincide on dut4: release wins, no pulse
      rst = 1'b1; req = 4'b0000; rel = 1'b0; p1 = 8'd0;
      step();
      rst = 1'b0; req = 4'b0001;
      step(); step(); step();
      check("d4_grant", {g4, v4, id4, to4}, expPack(4'b0001, 1'b0));
      step(); step(); step();
      check("d4_hold3", {g4, v4, id4, to4}, expPack(4'b0001, 1'b0));
      rel = 1'b1;
      step();
      check("d4_rel_vs_timeout", {g4, v4, id4, to4}, expPack(4'b0000, 1'b0));
      rel = 1'b0;
      // Without release, dut4 revokes after exactly 4 cycles
      step(); step(); step();
      check("d4_regrant", {g4, v4, id4, to4}, expPack(4'b0001, 1'b0));
      step(); step(); step();
      check("d4_hold_last", {g4, v4, id4, to4}, expPack(4'b0001, 1'b0));
      step();
      check("d4_timeout", {g4, v4, id4, to4}, expPack(4'b0000, 1'b1));
      req = 4'b0000;
      step();
      check("d4_timeout_pulse_end", {g4, v4, id4, to4}, expPack(4'b0000, 1'b0));

      // Reset while node4 owns the grant
      rst = 1'b1;
      step();
      rst = 1'b0; req = 4'b1000;
      step(); step(); step();
      check("n4_grant", {g8, v8, id8, to8}, expPack(4'b1000, 1'b0));
      rst = 1'b1;
      step();
      check("reset_mid_grant", {g8, v8, id8, to8}, expPack(4'b0000, 1'b0));
      rst = 1'b0; req = 4'b1111;
      step();
      check("post_rst_reload", {g8, v8, id8, to8}, expPack(4'b0000, 1'b0));
      step();
      check("post_rst_idle", {g8, v8, id8, to8}, expPack(4'b0000, 1'b0));
      step();
      check("post_rst_n1_first", {g8, v8, id8, to8}, expPack(4'b0001, 1'b0));
      rel = 1'b1; req = 4'b0000;
      step();
      check("post_rst_release", {g8, v8, id8, to8}, expPack(4'b0000, 1'b0));
      rel = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
